// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register sequencer: command ops, register sel codes, FSM states.
package shift_seq_pkg;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_SAR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external universal shift register: one load cycle, then N shift cycles.
// Optional macro SHIFT_SEQ_ROTATE_EN enables op 11 as rotate-right; otherwise op 11 acts as SHR logical.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4  // 2**AMT_W must exceed WIDTH
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_in,
  output logic             sr_rightshift,
  output logic             sr_leftshift,
  input  logic [WIDTH-1:0] sr_out,
  output logic [1:0]       dbg_state
);

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // cmd_valid/cmd_* and rsp_valid/rsp_data stay stable until their transfer completes.

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_dec;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign op_dec = cmd_op;
`else
  assign op_dec = (cmd_op == OP_ROR) ? OP_SHR : cmd_op;
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      data_q <= '0;
      fill_q <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_dec;
            data_q <= cmd_data;
            fill_q <= cmd_fill;
            cnt    <= (cmd_amt > AMT_MAX) ? AMT_MAX : cmd_amt;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: state <= (cnt == '0) ? ST_DONE : ST_SHIFT;
        ST_SHIFT: begin
          cnt <= cnt - AMT_ONE;
          if (cnt == AMT_ONE) state <= ST_DONE;
        end
        ST_DONE: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sr_sel        = SEL_HOLD;
    sr_in         = '0;
    sr_rightshift = 1'b0;
    sr_leftshift  = 1'b0;
    unique case (state)
      ST_LOAD: begin
        sr_sel = SEL_LOAD;
        sr_in  = data_q;
      end
      ST_SHIFT: begin
        if (op_q == OP_SHL) begin
          sr_sel       = SEL_LEFT;
          sr_leftshift = fill_q;
        end else begin
          sr_sel = SEL_RIGHT;
          case (op_q)
            OP_SAR:  sr_rightshift = sr_out[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR:  sr_rightshift = sr_out[0];
`endif
            default: sr_rightshift = fill_q;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE) && !sync_reset;
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rsp_valid ? sr_out : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural shift register; directed commands, queued expectations.
module tb_shift_seq_ctrl;

  localparam int W = 8;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         sync_reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [A-1:0] cmd_amt = '0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_fill = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [1:0]   sr_sel;
  logic [W-1:0] sr_in;
  logic         sr_rightshift;
  logic         sr_leftshift;
  logic [W-1:0] sr_out;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           stall_q[$];

  shift_seq_ctrl #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sr_sel(sr_sel), .sr_in(sr_in), .sr_rightshift(sr_rightshift),
    .sr_leftshift(sr_leftshift), .sr_out(sr_out), .dbg_state(dbg_state)
  );

  // clock / reset block and the controlled register
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (sync_reset) sr_q <= '0;
    else begin
      case (sr_sel)
        2'b11: sr_q <= sr_in;
        2'b01: sr_q <= {sr_q[W-2:0], sr_leftshift};
        2'b10: sr_q <= {sr_rightshift, sr_q[W-1:1]};
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_out = sr_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: issues one command, queues its expectation, and checks the sel/sr_in sequence
  task automatic send_cmd(input logic [1:0] op, input int amt, input logic [W-1:0] data,
                          input logic fill, input logic [W-1:0] exp_data, input int stall);
    int n;
    int guard;
    logic [1:0] shift_sel;
    n = (amt > W) ? W : amt;
    shift_sel = (op == 2'b00) ? 2'b01 : 2'b10;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_amt = A'(amt);
    cmd_data = data;
    cmd_fill = fill;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("cmd_accept_timeout", 32'd1, 32'd0);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    exp_q.push_back(exp_data);
    lat_q.push_back(n + 1);
    acc_q.push_back(cyc);
    stall_q.push_back(stall);
    cmd_valid = 1'b0;
    check("load_sel", 32'(sr_sel), 32'h3);
    check("load_in", 32'(sr_in), 32'(data));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("shift_sel", 32'(sr_sel), 32'(shift_sel));
      check("shift_in_zero", 32'(sr_in), 32'h0);
    end
    @(negedge clk);
    check("done_sel", 32'(sr_sel), 32'h0);
    check("done_pins", 32'({sr_rightshift, sr_leftshift}), 32'h0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] exp;
    int lat;
    int acc;
    int stall;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_data), 32'h0);
          checks--;
          check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
          rsp_ready = 1'b1;
          @(negedge clk);
          rsp_ready = 1'b0;
        end else begin
          exp = exp_q.pop_front();
          lat = lat_q.pop_front();
          acc = acc_q.pop_front();
          stall = stall_q.pop_front();
          check("rsp_latency", 32'(cyc - acc), 32'(lat));
          check("rsp_data", 32'(rsp_data), 32'(exp));
          for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'h1);
            check("stall_data", 32'(rsp_data), 32'(exp));
            check("stall_sel", 32'(sr_sel), 32'h0);
            check("stall_cmd_ready", 32'(cmd_ready), 32'h0);
          end
          rsp_ready = 1'b1;
          @(negedge clk);
          rsp_ready = 1'b0;
          check("post_hs_state", 32'(dbg_state), 32'h0);
          check("post_hs_ready", 32'(cmd_ready), 32'h1);
          check("post_hs_valid", 32'(rsp_valid), 32'h0);
          check("post_hs_data", 32'(rsp_data), 32'h0);
        end
      end
    end
  end

  initial begin
    int guard;
    logic [W-1:0] ror_exp;
`ifdef SHIFT_SEQ_ROTATE_EN
    ror_exp = 8'b1011_0111;
`else
    ror_exp = 8'b0001_0111;
`endif
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_sel", 32'(sr_sel), 32'h0);
    check("rst_in", 32'(sr_in), 32'h0);
    check("rst_pins", 32'({sr_rightshift, sr_leftshift}), 32'h0);
    sync_reset = 1'b0;
    #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    send_cmd(2'b00, 3,  8'b1011_1101, 1'b0, 8'b1110_1000, 0);
    send_cmd(2'b10, 2,  8'b1011_1101, 1'b0, 8'b1110_1111, 3);
    send_cmd(2'b01, 2,  8'b1011_1101, 1'b0, 8'b0010_1111, 0);
    send_cmd(2'b01, 0,  8'b1011_1101, 1'b0, 8'b1011_1101, 1);
    send_cmd(2'b00, 12, 8'b0000_0000, 1'b1, 8'b1111_1111, 0);
    send_cmd(2'b11, 3,  8'b1011_1101, 1'b0, ror_exp, 0);
    send_cmd(2'b00, 8,  8'b1111_1111, 1'b0, 8'b0000_0000, 0);
    send_cmd(2'b01, 15, 8'b0000_0000, 1'b1, 8'b1111_1111, 2);
    send_cmd(2'b10, 1,  8'b0100_0000, 1'b1, 8'b0010_0000, 0);

    guard = 0;
    while ((exp_q.size() != 0 || dbg_state != 2'b00) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(guard >= 200), 32'h0);

    // reset during the second shift cycle drops the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_amt = 4'd5; cmd_data = 8'hA5; cmd_fill = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_shift_sel", 32'(sr_sel), 32'h1);
    sync_reset = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_sel", 32'(sr_sel), 32'h0);
    check("mid_rst_ready_forced", 32'(cmd_ready), 32'h0);
    sync_reset = 1'b0;
    #1;
    check("after_rst_ready", 32'(cmd_ready), 32'h1);
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command-driven sequencer for the team's 8-bit universal shift register, which uses the sel encoding 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- Accepts one shift command (op, amount, data, fill) over a valid/ready handshake.
- Drives the register's sel, parallel-in and serial-in pins: one load cycle, then N shift cycles.
- Returns the shifted word over a valid/ready response channel.
- Sits between a host or bus-side requester and the register instance.

Parameters:
WIDTH, 8, register width; must match the controlled register.
AMT_W, 4, command shift-amount width; must satisfy 2**AMT_W > WIDTH.

Ports:
clk  input  1  single clock; all state updates on rising edge
sync_reset  input  1  synchronous, active-high reset; also wired to the controlled register
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 SHL logical, 01 SHR logical, 10 SHR arithmetic, 11 ROR
cmd_amt  input  AMT_W  requested shift count
cmd_data  input  WIDTH  word to load
cmd_fill  input  1  serial fill bit for logical ops
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  WIDTH  shifted result; 0 when rsp_valid=0
sr_sel  output  2  to register sel
sr_in  output  WIDTH  to register parallel input
sr_rightshift  output  1  serial-in bit entering MSB on a right shift
sr_leftshift  output  1  serial-in bit entering LSB on a left shift
sr_out  input  WIDTH  register parallel output

Behaviour:
- Register contract:
  - sel=10: out <= {rightshift, out[W-1:1]}.
  - sel=01: out <= {out[W-2:0], leftshift}.
  - sel=11: out <= in.
  - sel=00: hold.
- FSM states: IDLE, LOAD, SHIFT, DONE. State register and the registers op_q, data_q, fill_q and cnt (AMT_W bits) all reset to IDLE/0.
- IDLE:
  - cmd_ready=1 (forced 0 while sync_reset=1); sr_sel=00.
  - On cmd_valid&cmd_ready: capture op, data and fill.
  - Capture cnt = min(cmd_amt, WIDTH); amounts above WIDTH saturate to WIDTH.
  - Go to LOAD.
- LOAD: sr_sel=11, sr_in=data_q. Next state is DONE if cnt==0, else SHIFT.
- SHIFT:
  - sr_sel=01 for SHL, 10 for all other ops.
  - cnt decrements each cycle; leave to DONE in the cycle where cnt==1.
  - Serial-in for SHL and SHR logical: fill_q.
  - Serial-in for SHR arithmetic: sr_out[W-1].
  - Serial-in for ROR: sr_out[0], fed to sr_rightshift.
  - The inactive serial pin is driven 0.
- DONE:
  - sr_sel=00; rsp_valid=1; rsp_data=sr_out, stable while held.
  - On rsp_ready go to IDLE. Back-to-back commands are accepted no earlier than the cycle after the response handshake.
- Latency: with acceptance at edge T, rsp_valid=1 from cycle T+2+min(amt,WIDTH).
- Output outside LOAD: sr_in = 0.
- Output outside SHIFT: both serial pins = 0.
- Reset:
  - sync_reset=1 in any state: next state IDLE, all registers cleared, outputs at reset values next cycle.
  - Reset values: sr_sel=00, rsp_valid=0, rsp_data=0, sr_in=0, serial pins 0.
  - A command or response in flight is dropped with no handshake completion.
- cmd_valid while busy: ignored, since cmd_ready=0. The requester must hold its command.

Optional Feature:
SHIFT_SEQ_ROTATE_EN
- Defined: op 11 performs rotate-right as above.
- Undefined: op 11 decodes as SHR logical using cmd_fill, and no sr_out[0] feedback path is synthesised.

Decomposition:
- Shared include/package shift_seq_pkg holds:
  - op encodings: OP_SHL, OP_SHR, OP_SAR, OP_ROR.
  - register sel encodings: SEL_HOLD, SEL_LEFT, SEL_RIGHT, SEL_LOAD.
  - FSM state encodings.
- No sub-module is needed: the counter and FSM stay inline.
- A separate integration top pairs shift_seq_ctrl with the register; that top is not part of this block.

Test Plan:
- Reset, then SHL, amt=3, data=1011_1101, fill=0 -> rsp_valid at T+5, rsp_data=1110_1000; sr_sel sequence 11,01,01,01,00.
- SAR, amt=2, data=1011_1101 -> rsp_data=1110_1111 at T+4. SHR logical, same data, fill=0 -> 0010_1111.
- SHR logical, amt=0, data=1011_1101 -> only the load cycle, rsp_valid at T+2, rsp_data=1011_1101.
- SHL, amt=12, fill=1, data=0000_0000 -> saturates to 8 shifts, rsp_valid at T+10, rsp_data=1111_1111.
- Response with rsp_ready low for 3 cycles -> rsp_valid and rsp_data held stable, sr_sel=00, cmd_ready=0; then IDLE the cycle after the handshake.
- sync_reset pulsed during the second SHIFT cycle -> next cycle IDLE, rsp_valid=0, sr_sel=00, no response emitted.
- With SHIFT_SEQ_ROTATE_EN: ROR, amt=3, data=1011_1101 -> rsp_data=1011_0111. Without the macro: same command, fill=0 -> 0001_0111.
